// File: rtl/led_pwm_engine.sv
// Multi-channel LED PWM engine: prescaled tick, shared PWM/blink counters,
// double-buffered per-channel config. Optional mode 4 BREATHE via LED_PWM_BREATHE_EN.
module led_pwm_engine #(
    parameter int NUM_CH   = 10,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50,
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW      = PWM_BITS + 5
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              cfg_wr,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [DW-1:0]     cfg_data,
    output logic              cfg_err,
    output logic              pwm_wrap,
    output logic [NUM_CH-1:0] led
);

    localparam int PSW = $clog2(PRESCALE);
    localparam logic [PSW-1:0]      PRE_LAST = PSW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
    localparam logic [2:0] MODE_ON    = 3'd1;
    localparam logic [2:0] MODE_PWM   = 3'd2;
    localparam logic [2:0] MODE_BLINK = 3'd3;
`ifdef LED_PWM_BREATHE_EN
    localparam logic [2:0] MODE_BREATHE = 3'd4;
`endif

    logic [PSW-1:0]      presc_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [11:0]         blink_cnt_r;
    logic [DW-1:0]       shadow_r      [NUM_CH];
    logic [DW-1:0]       active_r      [NUM_CH];
    logic [DW-1:0]       next_shadow_s [NUM_CH];
    logic [NUM_CH-1:0]   led_s;
    logic                tick_s;
    logic                boundary_s;
    logic                wr_bad_s;
    logic                wr_ok_s;

    function automatic logic [2:0] mode_of(input logic [DW-1:0] cfg);
        return cfg[DW-1 -: 3];
    endfunction

    function automatic logic [1:0] rate_of(input logic [DW-1:0] cfg);
        return cfg[PWM_BITS+1 -: 2];
    endfunction

    function automatic logic [PWM_BITS-1:0] duty_of(input logic [DW-1:0] cfg);
        return cfg[PWM_BITS-1:0];
    endfunction

    // Full-scale duty must be solid on, which a plain less-than cannot reach.
    function automatic logic pwm_cmp(input logic [PWM_BITS-1:0] duty,
                                     input logic [PWM_BITS-1:0] cnt);
        return (duty == CNT_MAX) || (cnt < duty);
    endfunction

    function automatic logic blink_sel(input logic [11:0] blk, input logic [1:0] rate);
        case (rate)
            2'd0:    return blk[8];
            2'd1:    return blk[9];
            2'd2:    return blk[10];
            2'd3:    return blk[11];
            default: return 1'b0;
        endcase
    endfunction

    assign tick_s     = (presc_r == PRE_LAST);
    assign boundary_s = tick_s && (pwm_cnt_r == CNT_MAX);
    assign wr_bad_s   = cfg_wr && ({1'b0, cfg_ch} >= (CW+1)'(NUM_CH));
    assign wr_ok_s    = cfg_wr && !wr_bad_s;

    // Prescaler, PWM counter, blink counter and status pulses.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            presc_r     <= '0;
            pwm_cnt_r   <= '0;
            blink_cnt_r <= 12'd0;
            pwm_wrap    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            presc_r <= tick_s ? '0 : presc_r + PSW'(1);
            if (tick_s) begin
                pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            end
            if (boundary_s) begin
                blink_cnt_r <= blink_cnt_r + 12'd1;
            end
            pwm_wrap <= boundary_s;
            cfg_err  <= wr_bad_s;
        end
    end

    // Shadow contents after this cycle's write, so a boundary write reaches active.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok_s && (cfg_ch == CW'(i))) begin
                next_shadow_s[i] = cfg_data;
            end else begin
                next_shadow_s[i] = shadow_r[i];
            end
        end
    end

    // Shadow/active configuration registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= next_shadow_s[i];
                if (boundary_s) begin
                    active_r[i] <= next_shadow_s[i];
                end
            end
        end
    end

`ifdef LED_PWM_BREATHE_EN
    logic [PWM_BITS-1:0] level_r [NUM_CH];
    logic [NUM_CH-1:0]   fall_r;

    function automatic logic step_due(input logic [11:0] blk, input logic [1:0] rate);
        case (rate)
            2'd0:    return 1'b1;
            2'd1:    return (blk[0] == 1'b0);
            2'd2:    return (blk[1:0] == 2'b00);
            2'd3:    return (blk[2:0] == 3'b000);
            default: return 1'b1;
        endcase
    endfunction

    // Breathe level ramps up then down; restarts when a channel enters BREATHE.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            fall_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                level_r[i] <= '0;
            end
        end else if (boundary_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((mode_of(next_shadow_s[i]) == MODE_BREATHE) &&
                    (mode_of(active_r[i]) != MODE_BREATHE)) begin
                    level_r[i] <= '0;
                    fall_r[i]  <= 1'b0;
                end else if ((mode_of(active_r[i]) == MODE_BREATHE) &&
                             step_due(blink_cnt_r, rate_of(active_r[i]))) begin
                    if (!fall_r[i]) begin
                        if (level_r[i] == CNT_MAX) begin
                            level_r[i] <= CNT_MAX - PWM_BITS'(1);
                            fall_r[i]  <= 1'b1;
                        end else begin
                            level_r[i] <= level_r[i] + PWM_BITS'(1);
                        end
                    end else begin
                        if (level_r[i] == '0) begin
                            level_r[i] <= PWM_BITS'(1);
                            fall_r[i]  <= 1'b0;
                        end else begin
                            level_r[i] <= level_r[i] - PWM_BITS'(1);
                        end
                    end
                end
            end
        end
    end
`endif

    // Per-channel mode decode against the current counter values.
    always_comb begin
        led_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_of(active_r[i]))
                MODE_ON:    led_s[i] = 1'b1;
                MODE_PWM:   led_s[i] = pwm_cmp(duty_of(active_r[i]), pwm_cnt_r);
                MODE_BLINK: led_s[i] = pwm_cmp(duty_of(active_r[i]), pwm_cnt_r) &&
                                       blink_sel(blink_cnt_r, rate_of(active_r[i]));
`ifdef LED_PWM_BREATHE_EN
                MODE_BREATHE: led_s[i] = pwm_cmp(level_r[i], pwm_cnt_r);
`endif
                default:    led_s[i] = 1'b0;
            endcase
        end
    end

    // LED outputs sample the decode only on tick cycles.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            led <= '0;
        end else if (tick_s) begin
            led <= led_s;
        end else begin
            led <= led;
        end
    end

endmodule

// File: tb/tb_led_pwm_engine.sv
// Scoreboard bench for led_pwm_engine: a tick/period-level reference model
// pushes expected outputs each clock; a negedge monitor pops and compares.
module tb_led_pwm_engine;

    // Five channels so that cfg_ch=5 is both encodable and out of range.
    localparam int NUM_CH   = 5;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;
    localparam int CW       = 3;
    localparam int DW       = PWM_BITS + 5;
    localparam int MAXC     = 15;
    localparam int PERIOD   = PRESCALE * 16;

    logic              CLOCK_50 = 1'b0;
    logic              reset_n  = 1'b0;
    logic              cfg_wr   = 1'b0;
    logic [CW-1:0]     cfg_ch   = '0;
    logic [DW-1:0]     cfg_data = '0;
    logic              cfg_err;
    logic              pwm_wrap;
    logic [NUM_CH-1:0] led;

    led_pwm_engine #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .pwm_wrap(pwm_wrap), .led(led)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [NUM_CH-1:0] led;
        logic              wrap;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int sh_mode[NUM_CH], sh_rate[NUM_CH], sh_duty[NUM_CH];
    int ac_mode[NUM_CH], ac_rate[NUM_CH], ac_duty[NUM_CH];
    int lvl[NUM_CH], fall[NUM_CH];
    int edges;
    int t, cnt, blk;
    bit tick, bnd;
    logic [NUM_CH-1:0] m_led;
    exp_t me, mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic led_model(input int mode, input int rate, input int duty,
                                       input int level, input int c, input int b);
        bit on_cmp;
        on_cmp = (duty == MAXC) || (c < duty);
        case (mode)
            1: return 1'b1;
            2: return on_cmp;
            3: return on_cmp && (((b >> (8 + rate)) & 1) == 1);
`ifdef LED_PWM_BREATHE_EN
            4: return (level == MAXC) || (c < level);
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: time is edges since reset release; tick/period derived arithmetically.
    always @(posedge CLOCK_50) begin
        if (!reset_n) begin
            edges = 0;
            m_led = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_mode[i] = 0; sh_rate[i] = 0; sh_duty[i] = 0;
                ac_mode[i] = 0; ac_rate[i] = 0; ac_duty[i] = 0;
                lvl[i] = 0; fall[i] = 0;
            end
            me.led = '0; me.wrap = 1'b0; me.err = 1'b0;
            sb.push_back(me);
        end else begin
            tick = (edges % PRESCALE) == PRESCALE - 1;
            t    = edges / PRESCALE;
            cnt  = t % 16;
            blk  = (t / 16) % 4096;
            bnd  = tick && (cnt == MAXC);
            if (tick) begin
                for (int i = 0; i < NUM_CH; i++)
                    m_led[i] = led_model(ac_mode[i], ac_rate[i], ac_duty[i], lvl[i], cnt, blk);
            end
            me.err = cfg_wr && (cfg_ch >= NUM_CH);
            if (cfg_wr && (cfg_ch < NUM_CH)) begin
                sh_mode[cfg_ch] = int'(cfg_data[8:6]);
                sh_rate[cfg_ch] = int'(cfg_data[5:4]);
                sh_duty[cfg_ch] = int'(cfg_data[3:0]);
            end
            if (bnd) begin
                for (int i = 0; i < NUM_CH; i++) begin
`ifdef LED_PWM_BREATHE_EN
                    if (sh_mode[i] == 4 && ac_mode[i] != 4) begin
                        lvl[i] = 0; fall[i] = 0;
                    end else if (ac_mode[i] == 4 && (blk % (1 << ac_rate[i])) == 0) begin
                        if (fall[i] == 0) begin
                            if (lvl[i] == MAXC) begin lvl[i] = MAXC - 1; fall[i] = 1; end
                            else lvl[i] = lvl[i] + 1;
                        end else begin
                            if (lvl[i] == 0) begin lvl[i] = 1; fall[i] = 0; end
                            else lvl[i] = lvl[i] - 1;
                        end
                    end
`endif
                    ac_mode[i] = sh_mode[i]; ac_rate[i] = sh_rate[i]; ac_duty[i] = sh_duty[i];
                end
            end
            me.led  = m_led;
            me.wrap = bnd;
            sb.push_back(me);
            edges++;
        end
    end

    always @(negedge reset_n) sb.delete();

    // Monitor: compares every presented output against the queued expectation.
    always @(negedge CLOCK_50) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("led", 32'(led), 32'(mon_e.led));
            check("pwm_wrap", 32'(pwm_wrap), 32'(mon_e.wrap));
            check("cfg_err", 32'(cfg_err), 32'(mon_e.err));
        end
    end

    task automatic cfg_write(input int ch, input int mode, input int rate, input int duty,
                             input bit aligned);
        int k;
        k = 0;
        @(negedge CLOCK_50);
        while (aligned && (edges % PERIOD) != PERIOD - 1 && k < 4 * PERIOD) begin
            @(negedge CLOCK_50);
            k++;
        end
        if (aligned) check("boundary_align", 32'(edges % PERIOD), 32'(PERIOD - 1));
        cfg_wr   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_data = {3'(mode), 2'(rate), 4'(duty)};
        @(negedge CLOCK_50);
        cfg_wr   = 1'b0;
    endtask

    task automatic count_on(input int ch, output int c);
        c = 0;
        repeat (PERIOD) begin
            @(negedge CLOCK_50);
            if (led[ch]) c++;
        end
    endtask

    int on_cnt;

    initial begin
        repeat (4) @(negedge CLOCK_50);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Duty sweep on channel 0, counted over one full period.
        cfg_write(0, 2, 0, 4, 1'b0);
        repeat (2 * PERIOD + 4) @(negedge CLOCK_50);
        count_on(0, on_cnt);
        check("duty4_count", 32'(on_cnt), 32'd8);
        cfg_write(0, 2, 0, 0, 1'b0);
        repeat (2 * PERIOD + 4) @(negedge CLOCK_50);
        count_on(0, on_cnt);
        check("duty0_count", 32'(on_cnt), 32'd0);
        cfg_write(0, 2, 0, 15, 1'b0);
        repeat (2 * PERIOD + 4) @(negedge CLOCK_50);
        count_on(0, on_cnt);
        check("duty15_count", 32'(on_cnt), 32'd32);

        // Mid-period and boundary-cycle writes.
        cfg_write(0, 2, 0, 9, 1'b0);
        repeat (PERIOD + 7) @(negedge CLOCK_50);
        cfg_write(0, 2, 0, 3, 1'b1);
        repeat (PERIOD + 3) @(negedge CLOCK_50);

        // Out-of-range channel.
        cfg_write(5, 1, 0, 0, 1'b0);
        cfg_write(7, 1, 0, 0, 1'b1);
        repeat (PERIOD) @(negedge CLOCK_50);

        // Mode 4 and undefined modes.
        cfg_write(2, 4, 0, 9, 1'b0);
        cfg_write(3, 6, 0, 15, 1'b0);
        repeat (3 * PERIOD) @(negedge CLOCK_50);

        // Randomized writes, some aligned to the boundary cycle.
        for (int r = 0; r < 40; r++) begin
            cfg_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                      $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 50)) @(negedge CLOCK_50);
        end

        // Blink at rate 0 with full duty, long enough to see bit 8 of blink_cnt rise.
        cfg_write(1, 3, 0, 15, 1'b0);
        repeat (8600) @(negedge CLOCK_50);

        // Reset mid-period with channels ON.
        for (int ch = 0; ch < NUM_CH; ch++) cfg_write(ch, 1, 0, 0, 1'b0);
        repeat (2 * PERIOD + 5) @(negedge CLOCK_50);
        cfg_write(0, 2, 0, 7, 1'b0);
        #1 reset_n = 1'b0;
        #1 check("led_async_reset", 32'(led), 32'd0);
        repeat (3) @(negedge CLOCK_50);
        #1 reset_n = 1'b1;
        repeat (3 * PERIOD) @(negedge CLOCK_50);

`ifdef LED_PWM_BREATHE_EN
        cfg_write(4, 4, 0, 0, 1'b0);
        repeat (35 * PERIOD) @(negedge CLOCK_50);
`endif

        @(negedge CLOCK_50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures",
                 n_checks, n_fail);
        $fatal(1);
    end

endmodule
